data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_if.sv | 24 ++
 rtl/data_memory_ctrl.sv | 117 +++++++++++
 tb/tb_data_memory_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bus between a load/store unit and data_memory_ctrl
interface data_memory_ctrl_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
);
  logic req_valid;
  logic req_ready;
  logic MemRead;
  logic MemWrite;
  logic [2:0] Funct3;
  logic [DM_ADDRESS-1:0] a;
  logic [DATA_W-1:0] wd;
  logic resp_valid;
  logic [DATA_W-1:0] rd;
  logic fault;
  modport master (
    output req_valid, MemRead, MemWrite, Funct3, a, wd,
    input req_ready, resp_valid, rd, fault
  );
  modport slave (
    input req_valid, MemRead, MemWrite, Funct3, a, wd,
    output req_ready, resp_valid, rd, fault
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-lane data memory with RISC-V load/store decode; define DMEM_MISALIGN_EN to split word-crossing accesses into two beats
module data_memory_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset_n,
  data_memory_ctrl_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int NB2 = 2 * NB;
  localparam int LB = $clog2(NB);
  localparam int WA = DM_ADDRESS - LB;
  localparam int WORDS = 2 ** WA;
`ifdef DMEM_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BEAT2, RESP} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [WORDS];
  logic [2:0] f;
  logic [3:0] sz, sz_q;
  logic [WA-1:0] wa, wa2_q;
  logic [LB-1:0] off, off_q;
  logic sgn, sgn_q, ld_q, st_q;
  logic acc, mis, flt, split, wr_lo;
  logic [NB2-1:0] be2;
  logic [2*DATA_W-1:0] wd2;
  logic [NB-1:0] be_hi_q;
  logic [DATA_W-1:0] wd_hi_q, lo_q;

  // shift the two-word window down to the access, keep sz bytes, then sign- or zero-extend
  function automatic logic [DATA_W-1:0] fmt(input logic [2*DATA_W-1:0] pair, input logic [LB-1:0] o,
                                            input logic [3:0] s, input logic sg);
    logic [DATA_W-1:0] v, m;
    logic sb;
    v = DATA_W'(pair >> {o, 3'b000});
    m = ~({DATA_W{1'b1}} << {s, 3'b000});
    sb = |(v & m & ~(m >> 1));
    return (v & m) | ((sg && sb) ? ~m : '0);
  endfunction

  assign bus.req_ready = (state == IDLE);

  // decode size/sign, lane enables for both words and the fault/split decision for the offered request
  always_comb begin
    f = bus.Funct3;
    sz = (f == 3'b000 || f == 3'b100) ? 4'd1 :
         (f == 3'b001 || f == 3'b101) ? 4'd2 :
         (f == 3'b010) ? 4'd4 :
         (DATA_W == 64 && f == 3'b011) ? 4'd8 :
         (DATA_W == 64 && f == 3'b110) ? 4'd4 : 4'd0;
    sgn = ~f[2];
    wa = bus.a[DM_ADDRESS-1:LB];
    off = bus.a[LB-1:0];
    acc = bus.req_valid && state == IDLE && (bus.MemRead || bus.MemWrite);
    mis = |(off & LB'(sz - 4'd1));
    be2 = ((NB2'(1) << sz) - NB2'(1)) << off;
    wd2 = {{DATA_W{1'b0}}, bus.wd} << {off, 3'b000};
    flt = (bus.MemRead && bus.MemWrite) || sz == 4'd0 || (mis && !MIS_EN);
    split = MIS_EN && !flt && (|be2[NB2-1:NB]);
    wr_lo = acc && bus.MemWrite && !flt;
  end

  // memory lanes and second-beat context; deliberately not reset so contents survive reset_n
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_lo && be2[b]) mem[wa][b*8 +: 8] <= wd2[b*8 +: 8];
      if (state == BEAT2 && st_q && be_hi_q[b]) mem[wa2_q][b*8 +: 8] <= wd_hi_q[b*8 +: 8];
    end
    if (acc) begin
      wa2_q <= wa + WA'(1);
      off_q <= off;
      sz_q <= sz;
      sgn_q <= sgn;
      ld_q <= bus.MemRead;
      st_q <= bus.MemWrite;
      be_hi_q <= be2[NB2-1:NB];
      wd_hi_q <= wd2[2*DATA_W-1:DATA_W];
      lo_q <= mem[wa];
    end
  end

  // control FSM with registered response outputs; rd/fault hold between responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      bus.resp_valid <= 1'b0;
      bus.rd <= '0;
      bus.fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          state <= split ? BEAT2 : RESP;
          bus.resp_valid <= !split;
          if (!split) begin
            bus.rd <= (bus.MemRead && !flt) ? fmt({{DATA_W{1'b0}}, mem[wa]}, off, sz, sgn) : '0;
            bus.fault <= flt;
          end
        end
        BEAT2: begin
          state <= RESP;
          bus.resp_valid <= 1'b1;
          bus.rd <= ld_q ? fmt({mem[wa2_q], lo_q}, off_q, sz_q, sgn_q) : '0;
          bus.fault <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
          bus.resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed tests for data_memory_ctrl (DATA_W=32, DM_ADDRESS=9)
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int errors = 0;
  int checks = 0;
  logic [31:0] r_rd, exp_w10;
  logic r_fault;
  int r_lat;

  data_memory_ctrl_if #(.DM_ADDRESS(9), .DATA_W(32)) bus();
  data_memory_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut(.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!bus.req_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic drive(input logic rdn, input logic wrn, input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.MemRead = rdn;
    bus.MemWrite = wrn;
    bus.Funct3 = f3;
    bus.a = addr;
    bus.wd = data;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic do_req(input logic rdn, input logic wrn, input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] data);
    wait_ready();
    drive(rdn, wrn, f3, addr, data);
    r_lat = 0;
    r_rd = 'x;
    r_fault = 1'bx;
    for (int n = 1; n <= 4; n++) begin
      if (bus.resp_valid) begin
        r_lat = n;
        r_rd = bus.rd;
        r_fault = bus.fault;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.rd !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", bus.rd); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_word();
    do_req(1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL sw_latency: got %0d want 1", r_lat); end
    checks++; if (r_fault !== 1'b0 || r_rd !== 32'h0) begin errors++; $display("FAIL sw_resp: got fault=%b rd=%h want 0/0", r_fault, r_rd); end
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL lw_latency: got %0d want 1", r_lat); end
    checks++; if (r_rd !== 32'hDEADBEEF || r_fault !== 1'b0) begin errors++; $display("FAIL lw_rd: got %h/%b want deadbeef/0", r_rd, r_fault); end
    @(posedge clk);
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse_width: got %b want 0", bus.resp_valid); end
    checks++; if (bus.rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %h want deadbeef", bus.rd); end
  endtask

  task automatic test_byte();
    do_req(1'b0, 1'b1, 3'b000, 9'h013, 32'h00000080);
    checks++; if (r_fault !== 1'b0 || r_lat !== 1) begin errors++; $display("FAIL sb_resp: got fault=%b lat=%0d want 0/1", r_fault, r_lat); end
    do_req(1'b1, 1'b0, 3'b000, 9'h013, 32'h0);
    checks++; if (r_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h want ffffff80", r_rd); end
    do_req(1'b1, 1'b0, 3'b100, 9'h013, 32'h0);
    checks++; if (r_rd !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", r_rd); end
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    checks++; if (r_rd !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb: got %h want 80adbeef", r_rd); end
  endtask

  task automatic test_half();
    do_req(1'b0, 1'b1, 3'b010, 9'h014, 32'h0);
    do_req(1'b0, 1'b1, 3'b001, 9'h014, 32'hFFFF8001);
    do_req(1'b1, 1'b0, 3'b001, 9'h014, 32'h0);
    checks++; if (r_rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh: got %h want ffff8001", r_rd); end
    do_req(1'b1, 1'b0, 3'b101, 9'h014, 32'h0);
    checks++; if (r_rd !== 32'h00008001) begin errors++; $display("FAIL lhu: got %h want 00008001", r_rd); end
    do_req(1'b1, 1'b0, 3'b010, 9'h014, 32'h0);
    checks++; if (r_rd !== 32'h00008001) begin errors++; $display("FAIL lw_after_sh: got %h want 00008001", r_rd); end
  endtask

  task automatic test_fault();
    do_req(1'b1, 1'b1, 3'b010, 9'h010, 32'h0);
    checks++; if (r_lat !== 1 || r_fault !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL rw_both: got lat=%0d fault=%b rd=%h want 1/1/0", r_lat, r_fault, r_rd); end
    do_req(1'b0, 1'b1, 3'b111, 9'h010, 32'h0);
    checks++; if (r_fault !== 1'b1) begin errors++; $display("FAIL store_f3_111: got fault=%b want 1", r_fault); end
    do_req(1'b1, 1'b0, 3'b111, 9'h010, 32'h0);
    checks++; if (r_fault !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL load_f3_111: got fault=%b rd=%h want 1/0", r_fault, r_rd); end
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    checks++; if (r_rd !== 32'h80ADBEEF || r_fault !== 1'b0) begin errors++; $display("FAIL mem_after_faults: got %h/%b want 80adbeef/0", r_rd, r_fault); end
  endtask

  task automatic test_ignore();
    wait_ready();
    bus.req_valid = 1'b1;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.a = 9'h010;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL ignore_no_op: got resp_valid=%b req_ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_misalign();
    do_req(1'b0, 1'b1, 3'b001, 9'h011, 32'h00001234);
`ifdef DMEM_MISALIGN_EN
    checks++; if (r_fault !== 1'b0 || r_lat !== 1) begin errors++; $display("FAIL sh_in_word: got fault=%b lat=%0d want 0/1", r_fault, r_lat); end
    do_req(1'b1, 1'b0, 3'b101, 9'h011, 32'h0);
    checks++; if (r_rd !== 32'h00001234 || r_fault !== 1'b0) begin errors++; $display("FAIL lhu_in_word: got %h/%b want 00001234/0", r_rd, r_fault); end
    exp_w10 = 32'h801234EF;
    do_req(1'b1, 1'b0, 3'b010, 9'h012, 32'h0);
    checks++; if (r_rd !== 32'h80018012 || r_lat !== 2) begin errors++; $display("FAIL lw_split: got %h lat=%0d want 80018012/2", r_rd, r_lat); end
`else
    checks++; if (r_fault !== 1'b1 || r_rd !== 32'h0 || r_lat !== 1) begin errors++; $display("FAIL sh_misaligned: got fault=%b rd=%h lat=%0d want 1/0/1", r_fault, r_rd, r_lat); end
    exp_w10 = 32'h80ADBEEF;
    do_req(1'b1, 1'b0, 3'b010, 9'h012, 32'h0);
    checks++; if (r_fault !== 1'b1 || r_rd !== 32'h0) begin errors++; $display("FAIL lw_misaligned: got fault=%b rd=%h want 1/0", r_fault, r_rd); end
`endif
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    checks++; if (r_rd !== exp_w10) begin errors++; $display("FAIL word10_after_sh: got %h want %h", r_rd, exp_w10); end
  endtask

  task automatic test_reset_resp();
    wait_ready();
    drive(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_resp: got %b want 1", bus.resp_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.rd !== 32'h0 || bus.fault !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got valid=%b rd=%h fault=%b ready=%b want 0/0/0/1", bus.resp_valid, bus.rd, bus.fault, bus.req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b1, 1'b0, 3'b010, 9'h010, 32'h0);
    checks++; if (r_rd !== exp_w10) begin errors++; $display("FAIL mem_kept_over_reset: got %h want %h", r_rd, exp_w10); end
  endtask

  task automatic test_wrap();
    do_req(1'b0, 1'b1, 3'b010, 9'h1FC, 32'h0);
    do_req(1'b0, 1'b1, 3'b010, 9'h000, 32'h0);
    do_req(1'b0, 1'b1, 3'b010, 9'h1FE, 32'hAABBCCDD);
`ifdef DMEM_MISALIGN_EN
    checks++; if (r_lat !== 2 || r_fault !== 1'b0) begin errors++; $display("FAIL sw_wrap: got lat=%0d fault=%b want 2/0", r_lat, r_fault); end
    do_req(1'b1, 1'b0, 3'b100, 9'h1FE, 32'h0);
    checks++; if (r_rd !== 32'hDD) begin errors++; $display("FAIL byte_1fe: got %h want dd", r_rd); end
    do_req(1'b1, 1'b0, 3'b100, 9'h1FF, 32'h0);
    checks++; if (r_rd !== 32'hCC) begin errors++; $display("FAIL byte_1ff: got %h want cc", r_rd); end
    do_req(1'b1, 1'b0, 3'b100, 9'h000, 32'h0);
    checks++; if (r_rd !== 32'hBB) begin errors++; $display("FAIL byte_000: got %h want bb", r_rd); end
    do_req(1'b1, 1'b0, 3'b100, 9'h001, 32'h0);
    checks++; if (r_rd !== 32'hAA) begin errors++; $display("FAIL byte_001: got %h want aa", r_rd); end
    do_req(1'b1, 1'b0, 3'b010, 9'h1FE, 32'h0);
    checks++; if (r_rd !== 32'hAABBCCDD || r_lat !== 2) begin errors++; $display("FAIL lw_wrap: got %h lat=%0d want aabbccdd/2", r_rd, r_lat); end
`else
    checks++; if (r_lat !== 1 || r_fault !== 1'b1) begin errors++; $display("FAIL sw_wrap_fault: got lat=%0d fault=%b want 1/1", r_lat, r_fault); end
    do_req(1'b1, 1'b0, 3'b010, 9'h1FC, 32'h0);
    checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL word_1fc_unchanged: got %h want 0", r_rd); end
    do_req(1'b1, 1'b0, 3'b010, 9'h000, 32'h0);
    checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL word_000_unchanged: got %h want 0", r_rd); end
`endif
  endtask

`ifdef DMEM_MISALIGN_EN
  task automatic test_reset_beat2();
    do_req(1'b0, 1'b1, 3'b010, 9'h1FC, 32'h0);
    do_req(1'b0, 1'b1, 3'b010, 9'h000, 32'h0);
    wait_ready();
    drive(1'b0, 1'b1, 3'b010, 9'h1FE, 32'h55667788);
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL beat2_state: got valid=%b ready=%b want 0/0", bus.resp_valid, bus.req_ready); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL beat2_reset: got ready=%b valid=%b want 1/0", bus.req_ready, bus.resp_valid); end
    @(posedge clk);
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL beat2_no_resp: got %b want 0", bus.resp_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b1, 1'b0, 3'b010, 9'h1FC, 32'h0);
    checks++; if (r_rd !== 32'h77880000) begin errors++; $display("FAIL first_beat_kept: got %h want 77880000", r_rd); end
    do_req(1'b1, 1'b0, 3'b010, 9'h000, 32'h0);
    checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL second_beat_dropped: got %h want 0", r_rd); end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Funct3 = 3'b000;
    bus.a = '0;
    bus.wd = '0;
    exp_w10 = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_ignore();
    test_misalign();
    test_reset_resp();
    test_wrap();
`ifdef DMEM_MISALIGN_EN
    test_reset_beat2();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
